// File: rtl/hqm_aw_id_alloc_arb.sv
// hqm_aw_id_alloc_arb
//   Shares one ID freelist among NUM_REQS requesters. Level requests are
//   arbitrated round-robin, at most one ID is popped per cycle, and the ID is
//   handed to the winner one cycle later. A per-requester cap limits the
//   number of outstanding IDs. Returns pass straight through to the freelist
//   push port and decrement the returning requester's count.
//
// Optional build macro:
//   HQM_AW_ID_ALLOC_ARB_OWNER_CHK_EN - tracks the owner of every allocated ID
//   and flags returns from a non-owner on the sticky err_owner output.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req               level request per requester
//   cfg_limit         packed per-requester outstanding cap (0 disables)
//   gnt_v/gnt_req/gnt_id  registered grant pulse, one-hot winner, ID
//   ret_v/ret_req/ret_id  ID return from a requester
//   fl_pop, fl_pop_id_v, fl_pop_id  freelist pop interface
//   fl_push, fl_push_id  freelist push interface
//   outstanding       packed per-requester outstanding count
//   err_underflow     sticky: return seen while that requester's count was 0
//   err_owner         (optional) sticky: return from a non-owner
module hqm_aw_id_alloc_arb #(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned NUM_IDS  = 16,
  localparam int unsigned ID_WIDTH  = $clog2(NUM_IDS),
  localparam int unsigned REQ_WIDTH = $clog2(NUM_REQS),
  localparam int unsigned CNT_WIDTH = $clog2(NUM_IDS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQS-1:0]           req,
  input  logic [NUM_REQS*CNT_WIDTH-1:0] cfg_limit,
  output logic                          gnt_v,
  output logic [NUM_REQS-1:0]           gnt_req,
  output logic [ID_WIDTH-1:0]           gnt_id,
  input  logic                          ret_v,
  input  logic [REQ_WIDTH-1:0]          ret_req,
  input  logic [ID_WIDTH-1:0]           ret_id,
  output logic                          fl_pop,
  input  logic                          fl_pop_id_v,
  input  logic [ID_WIDTH-1:0]           fl_pop_id,
  output logic                          fl_push,
  output logic [ID_WIDTH-1:0]           fl_push_id,
  output logic [NUM_REQS*CNT_WIDTH-1:0] outstanding,
  output logic                          err_underflow
`ifdef HQM_AW_ID_ALLOC_ARB_OWNER_CHK_EN
  ,
  output logic                          err_owner
`endif
);

  logic [CNT_WIDTH-1:0] cnt     [NUM_REQS];
  logic [CNT_WIDTH-1:0] cnt_nxt [NUM_REQS];
  logic [NUM_REQS-1:0]  elig;
  logic [NUM_REQS-1:0]  inc_vec;
  logic [NUM_REQS-1:0]  dec_vec;
  logic [REQ_WIDTH-1:0] rr_ptr;
  logic [REQ_WIDTH-1:0] winner;
  logic [REQ_WIDTH-1:0] scan_idx;
  logic                 found;
  logic                 pop;
  logic                 uflow;

  // Eligibility: requesting and below its cap.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      elig[i] = req[i] && (cnt[i] < cfg_limit[i*CNT_WIDTH +: CNT_WIDTH]);
    end
  end

  // Round-robin: first eligible index at or after rr_ptr, wrapping. The index
  // is wrapped explicitly so non-power-of-two NUM_REQS works.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      int unsigned idx;
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      scan_idx = REQ_WIDTH'(idx);
      if (!found && elig[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  assign pop        = rst_n && found && fl_pop_id_v;
  assign fl_pop     = pop;
  assign fl_push    = ret_v;
  assign fl_push_id = ret_id;

  // Count update. A grant and return to the same requester cancel; a return
  // against a zero count is flagged and leaves the count at 0.
  always_comb begin
    uflow   = 1'b0;
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      cnt_nxt[i] = cnt[i];
      inc_vec[i] = pop && (winner == REQ_WIDTH'(i));
      dec_vec[i] = ret_v && (ret_req == REQ_WIDTH'(i));
      if (dec_vec[i] && (cnt[i] == '0)) uflow = 1'b1;
      if (inc_vec[i] && !dec_vec[i] && (cnt[i] != '1)) begin
        cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
      end else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0)) begin
        cnt_nxt[i] = cnt[i] - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQS; i++) cnt[i] <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQS; i++) cnt[i] <= cnt_nxt[i];
      if (uflow) err_underflow <= 1'b1;
    end
  end

  // Grant register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_v   <= 1'b0;
      gnt_req <= '0;
      gnt_id  <= '0;
      rr_ptr  <= '0;
    end else begin
      gnt_v <= pop;
      if (pop) begin
        gnt_req <= NUM_REQS'(1) << winner;
        gnt_id  <= fl_pop_id;
        rr_ptr  <= (winner == REQ_WIDTH'(NUM_REQS - 1)) ? '0 : winner + REQ_WIDTH'(1);
      end else begin
        gnt_req <= '0;
      end
    end
  end

  always_comb begin
    outstanding = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      outstanding[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
    end
  end

`ifdef HQM_AW_ID_ALLOC_ARB_OWNER_CHK_EN
  logic [REQ_WIDTH-1:0] own_req [NUM_IDS];
  logic [NUM_IDS-1:0]   own_v;

  // Pop write follows the return clear so a same-cycle pop of the same ID wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_v     <= '0;
      err_owner <= 1'b0;
      for (int unsigned i = 0; i < NUM_IDS; i++) own_req[i] <= '0;
    end else begin
      if (ret_v) begin
        if (!own_v[ret_id] || (own_req[ret_id] != ret_req)) err_owner <= 1'b1;
        own_v[ret_id] <= 1'b0;
      end
      if (pop) begin
        own_v[fl_pop_id]   <= 1'b1;
        own_req[fl_pop_id] <= winner;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hqm_aw_id_alloc_arb.sv
module tb_hqm_aw_id_alloc_arb;

  localparam int NR = 4;
  localparam int CW = 5;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [NR*CW-1:0] cfg_limit;
  logic            gnt_v;
  logic [NR-1:0]   gnt_req;
  logic [IW-1:0]   gnt_id;
  logic            ret_v;
  logic [1:0]      ret_req;
  logic [IW-1:0]   ret_id;
  logic            fl_pop;
  logic            fl_pop_id_v;
  logic [IW-1:0]   fl_pop_id;
  logic            fl_push;
  logic [IW-1:0]   fl_push_id;
  logic [NR*CW-1:0] outstanding;
  logic            err_underflow;
`ifdef HQM_AW_ID_ALLOC_ARB_OWNER_CHK_EN
  logic            err_owner;
`endif

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [NR-1:0] rq;
    logic [IW-1:0] id;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  hqm_aw_id_alloc_arb #(.NUM_REQS(4), .NUM_IDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cfg_limit(cfg_limit),
    .gnt_v(gnt_v), .gnt_req(gnt_req), .gnt_id(gnt_id),
    .ret_v(ret_v), .ret_req(ret_req), .ret_id(ret_id),
    .fl_pop(fl_pop), .fl_pop_id_v(fl_pop_id_v), .fl_pop_id(fl_pop_id),
    .fl_push(fl_push), .fl_push_id(fl_push_id),
    .outstanding(outstanding), .err_underflow(err_underflow)
`ifdef HQM_AW_ID_ALLOC_ARB_OWNER_CHK_EN
    , .err_owner(err_owner)
`endif
  );

  // Freelist stand-in: FIFO of free IDs, head presented as pop_id.
  logic [IW-1:0] fl_q[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_q.delete();
      for (int i = 0; i < 16; i++) fl_q.push_back(IW'(i));
      fl_pop_id_v <= 1'b1;
      fl_pop_id   <= '0;
    end else begin
      if (fl_pop && fl_q.size() > 0) void'(fl_q.pop_front());
      if (fl_push) fl_q.push_back(fl_push_id);
      fl_pop_id_v <= (fl_q.size() != 0);
      fl_pop_id   <= (fl_q.size() != 0) ? fl_q[0] : '0;
    end
  end

  function automatic logic [CW-1:0] outs(input int i);
    return outstanding[i*CW +: CW];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; ret_v = 1'b0; ret_req = '0; ret_id = '0;
    cfg_limit = {4{5'd16}};
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111; ret_v = 1'b0; ret_req = '0; ret_id = '0;
    cfg_limit = {4{5'd16}};
    repeat (2) @(negedge clk);
    checks++; if (fl_pop !== 1'b0) $display("FAIL reset_fl_pop: got %b exp 0", fl_pop); else passed++;
    checks++; if (gnt_v !== 1'b0 || gnt_req !== 4'b0 || gnt_id !== 4'd0)
      $display("FAIL reset_gnt: got v=%b req=%b id=%0d exp 0/0/0", gnt_v, gnt_req, gnt_id); else passed++;
    checks++; if (outstanding !== '0 || err_underflow !== 1'b0)
      $display("FAIL reset_state: got out=%h uf=%b exp 0/0", outstanding, err_underflow); else passed++;
    req = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_rr_basic();
    int budget;
    do_reset();
    @(negedge clk);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) exp_q.push_back({4'(1 << k), 4'(k)});
    #1;
    checks++; if (fl_pop !== 1'b1 || gnt_v !== 1'b0)
      $display("FAIL first_pop: got pop=%b gnt_v=%b exp 1/0", fl_pop, gnt_v); else passed++;
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk); budget--;
      if (gnt_v) begin
        exp_t e = exp_q.pop_front();
        checks++; if (gnt_req !== e.rq || gnt_id !== e.id)
          $display("FAIL rr_grant: got req=%b id=%0d exp req=%b id=%0d", gnt_req, gnt_id, e.rq, e.id); else passed++;
      end
    end
    req = '0;
    checks++; if (exp_q.size() != 0) $display("FAIL rr_timeout: got %0d pending exp 0", exp_q.size()); else passed++;
    @(negedge clk);
    checks++; if (gnt_v !== 1'b0 || outstanding !== {4{5'd1}})
      $display("FAIL rr_after: got gnt_v=%b out=%h exp 0/%h", gnt_v, outstanding, {4{5'd1}}); else passed++;
  endtask

  task automatic test_limit();
    int budget;
    do_reset();
    cfg_limit[0*CW +: CW] = 5'd2;
    @(negedge clk);
    req = 4'b0101;
    exp_q.push_back({4'b0001, 4'd0});
    exp_q.push_back({4'b0100, 4'd1});
    exp_q.push_back({4'b0001, 4'd2});
    exp_q.push_back({4'b0100, 4'd3});
    exp_q.push_back({4'b0100, 4'd4});
    exp_q.push_back({4'b0100, 4'd5});
    budget = 12;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk); budget--;
      if (gnt_v) begin
        exp_t e = exp_q.pop_front();
        checks++; if (gnt_req !== e.rq || gnt_id !== e.id)
          $display("FAIL limit_grant: got req=%b id=%0d exp req=%b id=%0d", gnt_req, gnt_id, e.rq, e.id); else passed++;
      end
    end
    req = '0;
    checks++; if (exp_q.size() != 0) $display("FAIL limit_timeout: got %0d pending exp 0", exp_q.size()); else passed++;
    @(negedge clk);
    checks++; if (outs(0) !== 5'd2 || outs(2) !== 5'd4 || gnt_v !== 1'b0)
      $display("FAIL limit_counts: got o0=%0d o2=%0d v=%b exp 2/4/0", outs(0), outs(2), gnt_v); else passed++;
    // A zero limit disables the requester entirely.
    do_reset();
    cfg_limit[1*CW +: CW] = 5'd0;
    @(negedge clk);
    req = 4'b0010;
    #1;
    checks++; if (fl_pop !== 1'b0) $display("FAIL limit_zero_pop: got %b exp 0", fl_pop); else passed++;
    repeat (2) @(negedge clk);
    checks++; if (gnt_v !== 1'b0 || outs(1) !== 5'd0)
      $display("FAIL limit_zero: got v=%b o1=%0d exp 0/0", gnt_v, outs(1)); else passed++;
    req = '0;
  endtask

  task automatic test_exhaust_return();
    int budget;
    do_reset();
    @(negedge clk);
    req = 4'b1111;
    for (int k = 0; k < 16; k++) exp_q.push_back({4'(1 << (k % 4)), 4'(k)});
    budget = 24;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk); budget--;
      if (gnt_v) begin
        exp_t e = exp_q.pop_front();
        checks++; if (gnt_req !== e.rq || gnt_id !== e.id)
          $display("FAIL exh_grant: got req=%b id=%0d exp req=%b id=%0d", gnt_req, gnt_id, e.rq, e.id); else passed++;
      end
    end
    checks++; if (exp_q.size() != 0) $display("FAIL exh_timeout: got %0d pending exp 0", exp_q.size()); else passed++;
    #1;
    checks++; if (fl_pop !== 1'b0 || fl_pop_id_v !== 1'b0)
      $display("FAIL exh_pop: got pop=%b v=%b exp 0/0", fl_pop, fl_pop_id_v); else passed++;
    @(negedge clk);
    checks++; if (gnt_v !== 1'b0) $display("FAIL exh_gnt: got %b exp 0", gnt_v); else passed++;
    ret_v = 1'b1; ret_req = 2'd1; ret_id = 4'd5;
    exp_q.push_back({4'b0001, 4'd5});
    #1;
    checks++; if (fl_push !== 1'b1 || fl_push_id !== 4'd5)
      $display("FAIL exh_push: got push=%b id=%0d exp 1/5", fl_push, fl_push_id); else passed++;
    @(negedge clk);
    ret_v = 1'b0;
    budget = 4;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk); budget--;
      if (gnt_v) begin
        exp_t e = exp_q.pop_front();
        checks++; if (gnt_req !== e.rq || gnt_id !== e.id)
          $display("FAIL exh_regrant: got req=%b id=%0d exp req=%b id=%0d", gnt_req, gnt_id, e.rq, e.id); else passed++;
      end
    end
    req = '0;
    checks++; if (exp_q.size() != 0) $display("FAIL exh_regrant_timeout: got %0d pending exp 0", exp_q.size()); else passed++;
    checks++; if (outs(0) !== 5'd5 || outs(1) !== 5'd3)
      $display("FAIL exh_counts: got o0=%0d o1=%0d exp 5/3", outs(0), outs(1)); else passed++;
  endtask

  task automatic test_same_cycle();
    exp_t e;
    do_reset();
    @(negedge clk);
    req = 4'b1000;
    exp_q.push_back({4'b1000, 4'd0});
    exp_q.push_back({4'b1000, 4'd1});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (gnt_v !== 1'b1 || gnt_req !== e.rq || gnt_id !== e.id)
      $display("FAIL same_g1: got v=%b req=%b id=%0d exp 1/%b/%0d", gnt_v, gnt_req, gnt_id, e.rq, e.id); else passed++;
    ret_v = 1'b1; ret_req = 2'd3; ret_id = 4'd0;
    #1;
    checks++; if (fl_push !== 1'b1 || fl_push_id !== 4'd0 || fl_pop !== 1'b1)
      $display("FAIL same_push: got push=%b id=%0d pop=%b exp 1/0/1", fl_push, fl_push_id, fl_pop); else passed++;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (gnt_v !== 1'b1 || gnt_req !== e.rq || gnt_id !== e.id)
      $display("FAIL same_g2: got v=%b req=%b id=%0d exp 1/%b/%0d", gnt_v, gnt_req, gnt_id, e.rq, e.id); else passed++;
    checks++; if (outs(3) !== 5'd1) $display("FAIL same_count: got %0d exp 1", outs(3)); else passed++;
    req = '0; ret_v = 1'b0;
    @(negedge clk);
    checks++; if (gnt_v !== 1'b0 || outs(3) !== 5'd1)
      $display("FAIL same_after: got v=%b o3=%0d exp 0/1", gnt_v, outs(3)); else passed++;
  endtask

  task automatic test_underflow();
    @(negedge clk);
    ret_v = 1'b1; ret_req = 2'd2; ret_id = 4'd9;
    #1;
    checks++; if (fl_push !== 1'b1 || fl_push_id !== 4'd9 || err_underflow !== 1'b0)
      $display("FAIL uf_push: got push=%b id=%0d uf=%b exp 1/9/0", fl_push, fl_push_id, err_underflow); else passed++;
    @(negedge clk);
    ret_v = 1'b0;
    checks++; if (err_underflow !== 1'b1 || outs(2) !== 5'd0)
      $display("FAIL uf_set: got uf=%b o2=%0d exp 1/0", err_underflow, outs(2)); else passed++;
    repeat (3) @(negedge clk);
    checks++; if (err_underflow !== 1'b1) $display("FAIL uf_sticky: got %b exp 1", err_underflow); else passed++;
  endtask

`ifdef HQM_AW_ID_ALLOC_ARB_OWNER_CHK_EN
  task automatic test_owner();
    for (int pass = 0; pass < 2; pass++) begin
      int budget;
      do_reset();
      @(negedge clk);
      req = 4'b0010;
      for (int k = 0; k < 8; k++) exp_q.push_back({4'b0010, 4'(k)});
      budget = 12;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk); budget--;
        if (gnt_v) begin
          exp_t e = exp_q.pop_front();
          checks++; if (gnt_req !== e.rq || gnt_id !== e.id)
            $display("FAIL own_grant: got req=%b id=%0d exp req=%b id=%0d", gnt_req, gnt_id, e.rq, e.id); else passed++;
        end
      end
      req = '0;
      @(negedge clk);
      if (pass == 0) begin
        // Correct owner first, then a repeat return of the now-cleared entry.
        ret_v = 1'b1; ret_req = 2'd1; ret_id = 4'd6;
        @(negedge clk);
        ret_v = 1'b0;
        checks++; if (err_owner !== 1'b0) $display("FAIL own_ok: got %b exp 0", err_owner); else passed++;
        ret_v = 1'b1;
        @(negedge clk);
        ret_v = 1'b0;
        checks++; if (err_owner !== 1'b1) $display("FAIL own_cleared: got %b exp 1", err_owner); else passed++;
      end else begin
        ret_v = 1'b1; ret_req = 2'd0; ret_id = 4'd7;
        @(negedge clk);
        ret_v = 1'b0;
        checks++; if (err_owner !== 1'b1) $display("FAIL own_wrong: got %b exp 1", err_owner); else passed++;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rr_basic();
    test_limit();
    test_exhaust_return();
    test_same_cycle();
    test_underflow();
`ifdef HQM_AW_ID_ALLOC_ARB_OWNER_CHK_EN
    test_owner();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/hqm_aw_id_alloc_arb.md
Name: hqm_AW_id_alloc_arb

Overview:
Shares one hqm_AW_id_freelist_bb instance among NUM_REQS requesters.
- Arbitrates level requests round-robin, pops one ID per cycle from the freelist and returns it to the winner one cycle later.
- Enforces a programmable per-requester cap on outstanding IDs and forwards ID returns to the freelist push port.
- Sits between requesting pipes and the freelist inside the owning AW subsystem.

Parameters:
NUM_REQS, 4, number of requesters (>=2)
NUM_IDS, 16, IDs managed by the attached freelist
ID_WIDTH, AW_logb2(NUM_IDS-1)+1, ID width (derived, not overridden)
REQ_WIDTH, AW_logb2(NUM_REQS-1)+1, requester index width (derived)
CNT_WIDTH, AW_logb2(NUM_IDS)+1, outstanding-count/limit width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQS  level request per requester, one ID per grant
cfg_limit  in  NUM_REQS*CNT_WIDTH  max outstanding IDs per requester, quasi-static
gnt_v  out  1  grant valid, one-cycle pulse
gnt_req  out  NUM_REQS  one-hot winner, qualified by gnt_v
gnt_id  out  ID_WIDTH  allocated ID, qualified by gnt_v
ret_v  in  1  ID return valid
ret_req  in  REQ_WIDTH  index of returning requester
ret_id  in  ID_WIDTH  returned ID
fl_pop  out  1  to freelist pop
fl_pop_id_v  in  1  from freelist pop_id_v
fl_pop_id  in  ID_WIDTH  from freelist pop_id
fl_push  out  1  to freelist push (NUM_PUSHES=1)
fl_push_id  out  ID_WIDTH  to freelist push_id
outstanding  out  NUM_REQS*CNT_WIDTH  current outstanding count per requester
err_underflow  out  1  sticky: return while that requester's count was 0

Behaviour:
- Reset: gnt_v=0, gnt_req=0, gnt_id=0, all outstanding=0, err_underflow=0, rr pointer=0; fl_pop=0 while reset asserted.
- Eligibility (cycle N, combinational): elig[i] = req[i] & (outstanding[i] < cfg_limit[i]).
- Arbitration: winner = first elig index at or after rr pointer, wrapping.
- fl_pop = |elig & fl_pop_id_v, combinational in cycle N.
- Grant (cycle N+1, registered): gnt_v=1, gnt_req=onehot(winner), gnt_id=fl_pop_id captured at N. Latency is fixed at 1.
- Requesters see gnt in N+1 and may still hold req at N+1. That req counts as a new request; at most one grant per cycle in total.
- RR pointer: on a pop, becomes (winner+1) mod NUM_REQS. Otherwise unchanged.
- No pop when fl_pop_id_v=0 (freelist empty). In that case no grant, the pointer holds, and counts change only on returns.
- Returns: fl_push=ret_v and fl_push_id=ret_id, combinational pass-through. outstanding[ret_req] decrements at the clock edge.
- Same-cycle grant and return for the same requester: count unchanged. For different requesters: both update.
- Return when outstanding[ret_req]==0: count stays 0, err_underflow set until reset, push is still forwarded.
- cfg_limit[i]=0 disables requester i. A limit >= NUM_IDS means effectively unlimited. Lowering a limit below the current count blocks new grants but loses no state.
- Count saturates at 2^CNT_WIDTH-1. This is unreachable with a correct freelist.
- Reset mid-operation: all state clears immediately. IDs held by requesters are considered reclaimed by the freelist reset.

Optional Feature:
HQM_AW_ID_ALLOC_ARB_OWNER_CHK_EN
- Defined:
  - Adds an owner table of NUM_IDS entries, each REQ_WIDTH bits plus a valid bit.
  - On a pop, the entry for the popped ID is written with the winner and marked valid.
  - On a return, if the entry is invalid or its owner differs from ret_req, the sticky output err_owner (1 bit, reset 0) is set; the entry is cleared in all cases.
  - Pop and return of the same ID in the same cycle: the pop write wins.
- Undefined: no table, no err_owner port, behaviour otherwise identical.

Test Plan:
1. Reset, req=4'b1111, limits=16, freelist full: grants 1,2,3,4 go to req0,1,2,3 with IDs 0,1,2,3 in order; gnt_v rises one cycle after the first fl_pop.
2. req=4'b0101, limit[0]=2, no returns: req0 gets 2 grants interleaved with req2, then all remaining grants go to req2; outstanding[0]=2.
3. Hold all requests until 16 IDs are allocated: fl_pop_id_v=0, fl_pop=0, no gnt_v. One ret_v(req1,id 5): gnt_id=5 on the next grant.
4. Same-cycle grant to req3 and return from req3: outstanding[3] unchanged, fl_push=1 with the returned ID.
5. ret_v for req2 with outstanding[2]=0: err_underflow=1 and stays 1, outstanding[2]=0, fl_push=1.
6. (OWNER_CHK_EN) ID 7 granted to req1, returned as req0: err_owner=1. A subsequent return of ID 7 also sets err_owner (entry already cleared).
